// File: rtl/pll_reset_pkg.sv
// Shared types and width helpers for the PLL reset sequencer.
//   seq_state_e : sequencer FSM states
//   cnt_width   : width of the cycle counter for a filter window and stage delay
//   idx_width   : width of the stage index for a given stage count
package pll_reset_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK,
    FILTER,
    RELEASE,
    RUN,
    SW_HOLD
  } seq_state_e;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One extra bit so the counter can hold its terminal value for any legal
  // parameter set (including power-of-two windows).
  function automatic int cnt_width(input int filt_cycles, input int stage_delay);
    return $clog2(max_of(filt_cycles, stage_delay)) + 1;
  endfunction

  function automatic int idx_width(input int num_stages);
    return $clog2(num_stages) + 1;
  endfunction

endpackage

// File: rtl/cdc_sync.sv
// Single-bit multi-flop synchroniser for an asynchronous level input.
//   clk     : destination clock
//   reset_n : asynchronous active-low reset, clears all flops to 0
//   d_i     : asynchronous input
//   q_o     : d_i delayed by STAGES flops in the clk domain
module cdc_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Staged reset release driven by the PLL lock flag.
// Waits for a stable synchronised lock, then releases the active-low stage
// resets one at a time in index order. Lock loss (counted, saturating) or a
// software request re-asserts every stage together.
//   clk               : system clock, domain the resets are released into
//   reset_n           : asynchronous active-low reset
//   pll_locked_i      : PLL lock flag, asynchronous to clk
//   sw_reset_i        : single-cycle request to re-sequence the resets
//   stage_reset_n_o   : active-low stage resets, bit 0 released first
//   ready_o           : high while every stage is released
//   lock_loss_count_o : saturating count of lock-loss events
module pll_reset_sequencer
  import pll_reset_pkg::*;
#(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_FILTER_CYCLES = 1024,
  parameter int STAGE_DELAY        = 256,
  parameter int NUM_STAGES         = 3,
  parameter int LOSS_CNT_W         = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pll_locked_i,
  input  logic                  sw_reset_i,
  output logic [NUM_STAGES-1:0] stage_reset_n_o,
  output logic                  ready_o,
  output logic [LOSS_CNT_W-1:0] lock_loss_count_o
);

  localparam int CNT_W = cnt_width(LOCK_FILTER_CYCLES, STAGE_DELAY);
  localparam int IDX_W = idx_width(NUM_STAGES);

  localparam logic [CNT_W-1:0]      FILT_LAST  = CNT_W'(LOCK_FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0]      DELAY_LAST = CNT_W'(STAGE_DELAY - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_STAGES - 1);
  localparam logic [LOSS_CNT_W-1:0] LOSS_MAX   = '1;

  logic locked_s;

  seq_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      k_q, k_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic                  ready_q, ready_d;
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;

  logic lock_lost;
  logic sw_req;

  cdc_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (pll_locked_i),
    .q_o     (locked_s)
  );

  // Loss only counts once resets have started releasing; a drop during the
  // filter window is just an unstable lock and silently restarts the wait.
  assign lock_lost = !locked_s &&
                     ((state_q == RELEASE) || (state_q == RUN) || (state_q == SW_HOLD));
  // Lock loss takes priority over a simultaneous software request.
  assign sw_req    = sw_reset_i && !lock_lost &&
                     ((state_q == RELEASE) || (state_q == RUN));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    stage_d = stage_q;
    ready_d = ready_q;
    loss_d  = loss_q;

    if (lock_lost) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
      k_d     = '0;
      stage_d = '0;
      ready_d = 1'b0;
      if (loss_q != LOSS_MAX) begin
        loss_d = loss_q + LOSS_CNT_W'(1);
      end
    end else if (sw_req) begin
      state_d = SW_HOLD;
      cnt_d   = '0;
      k_d     = '0;
      stage_d = '0;
      ready_d = 1'b0;
    end else begin
      unique case (state_q)
        WAIT_LOCK: begin
          cnt_d   = '0;
          k_d     = '0;
          stage_d = '0;
          ready_d = 1'b0;
          if (locked_s) begin
            state_d = FILTER;
          end
        end
        FILTER: begin
          if (!locked_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == FILT_LAST) begin
            state_d = RELEASE;
            cnt_d   = '0;
            k_d     = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (cnt_q == DELAY_LAST) begin
            cnt_d = '0;
            k_d   = k_q + IDX_W'(1);
            for (int i = 0; i < NUM_STAGES; i++) begin
              if (k_q == IDX_W'(i)) begin
                stage_d[i] = 1'b1;
              end
            end
            // Ready rises on the same edge as the last stage.
            if (k_q == IDX_LAST) begin
              state_d = RUN;
              ready_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
        end
        SW_HOLD: begin
          // Software re-sequence trusts the lock already filtered once.
          if (cnt_q == DELAY_LAST) begin
            state_d = RELEASE;
            cnt_d   = '0;
            k_d     = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          k_d     = '0;
          stage_d = '0;
          ready_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      k_q     <= '0;
      stage_q <= '0;
      ready_q <= 1'b0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      stage_q <= stage_d;
      ready_q <= ready_d;
      loss_q  <= loss_d;
    end
  end

  assign stage_reset_n_o   = stage_q;
  assign ready_o           = ready_q;
  assign lock_loss_count_o = loss_q;

endmodule
